// File: rtl/tick_gen_pkg.sv
// Shared defaults and types for the multi-channel tick / slow-clock generator.
package tick_gen_pkg;

    // Default counter width and reset divisor used by the top and the channels.
    localparam int CNT_W_DEF   = 20;
    localparam int DEF_DIV_DEF = 100_000;

    // Divisor / counter word at the default width.
    typedef logic [CNT_W_DEF-1:0] div_t;

    // Architectural state of one channel at the default width.
    typedef struct packed {
        div_t cnt;
        div_t div_act;
        div_t div_pend;
        logic pend_vld;
    } ch_state_t;

    // True when a programmed divisor value disables a channel.
    function automatic logic div_is_off(input div_t div);
        return (div == '0);
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One divider channel: free-running counter, active and shadow divisor,
// registered 1-cycle tick strobe and 50%-duty square wave.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_act_nxt;
    logic [CNT_W-1:0] div_pend;
    logic [CNT_W-1:0] div_pend_nxt;
    logic             pend_vld;
    logic             pend_vld_nxt;
    logic             tick_nxt;
    logic             sq_nxt;

    logic             div_off;
    logic             running;
    logic             terminal;

    // A channel counts only while globally enabled with a non-zero divisor;
    // the terminal count is the last cycle of the current period.
    assign div_off  = (div_act == '0);
    assign running  = en && !div_off;
    assign terminal = running && (cnt == div_act - CNT_W'(1));

    // Next-state selection: sync beats terminal/write, which beat hold.
    always_comb begin
        cnt_nxt      = cnt;
        div_act_nxt  = div_act;
        div_pend_nxt = div_pend;
        pend_vld_nxt = pend_vld;
        tick_nxt     = 1'b0;
        sq_nxt       = sq;

        if (sync) begin
            // Restart in phase; a same-cycle write wins over an older pending value.
            cnt_nxt      = '0;
            sq_nxt       = 1'b0;
            pend_vld_nxt = 1'b0;
            if (wr) begin
                div_act_nxt = wr_div;
            end else if (pend_vld) begin
                div_act_nxt = div_pend;
            end
        end else if (terminal) begin
            // End of period: the tick belongs to the old divisor, then the
            // shadow divisor (if any) takes over for the next period.
            cnt_nxt  = '0;
            tick_nxt = 1'b1;
            sq_nxt   = ~sq;
            if (pend_vld) begin
                div_act_nxt  = div_pend;
                pend_vld_nxt = 1'b0;
                if (div_pend == '0) begin
                    sq_nxt = 1'b0;
                end
            end
            // A write landing on the terminal is deferred to the next terminal.
            if (wr) begin
                div_pend_nxt = wr_div;
                pend_vld_nxt = 1'b1;
            end
        end else if (running) begin
            // Mid-period: keep counting; writes are shadowed until the terminal.
            cnt_nxt = cnt + CNT_W'(1);
            if (wr) begin
                div_pend_nxt = wr_div;
                pend_vld_nxt = 1'b1;
            end
        end else begin
            // Frozen or disabled: writes apply at once and restart the count.
            if (wr) begin
                div_act_nxt  = wr_div;
                cnt_nxt      = '0;
                pend_vld_nxt = 1'b0;
                if (wr_div == '0) begin
                    sq_nxt = 1'b0;
                end
            end else if (div_off) begin
                cnt_nxt = '0;
                sq_nxt  = 1'b0;
            end
        end
    end

    // Channel state register with synchronous reset to the default divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_act  <= CNT_W'(DEF_DIV);
            div_pend <= '0;
            pend_vld <= 1'b0;
            tick     <= 1'b0;
            sq       <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_act  <= div_act_nxt;
            div_pend <= div_pend_nxt;
            pend_vld <= pend_vld_nxt;
            tick     <= tick_nxt;
            sq       <= sq_nxt;
        end
    end

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel clock-enable / slow-clock generator: decodes the divisor
// write port and replicates one divider channel per output.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sync,
    input  logic                    wr_en,
    input  logic [$clog2(NUM_CH):0] wr_ch,
    input  logic [CNT_W-1:0]        wr_div,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq
);

    localparam int CH_W = $clog2(NUM_CH) + 1;

    // One channel per output; the extra index bit keeps out-of-range
    // channel numbers from aliasing onto a real channel.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_sel;

        assign wr_sel = wr_en && (wr_ch == CH_W'(i));

        tick_gen_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .sync   (sync),
            .wr     (wr_sel),
            .wr_div (wr_div),
            .tick   (tick[i]),
            .sq     (sq[i])
        );
    end

endmodule
